mem_stall_sequencer: RTL and testbench

//  Parametrised M-stage memory stall sequencer for the N-issue MIPS pipeline; replaces the fixed 2-lane 20-cycle counter.

---
 rtl/mem_stall_sequencer.sv | 168 ++++++++++++++++
 tb/tb_mem_stall_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stall_sequencer.sv
// M-stage memory stall sequencer: serialises data-cache accesses lowest-lane-first through tag check, writeback and refill.
// Optional perf counters (stall_cycles, miss_count) are built only when MEM_STALL_PERF_EN is defined.
//
// state   | meaning
// IDLE    | no access in flight; picks lowest pending lane
// TAG     | tag check of cur_lane (hit/dirty sampled)
// WB      | dirty victim written back to main memory
// FILL    | line being fetched from main memory
// FILL_WR | refilled line written into the cache, then re-check
module mem_stall_sequencer #(
  parameter int LANES       = 2,
  parameter int MEM_LATENCY = 20,
  localparam int LW         = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LANES-1:0] mem_req,
  input  logic [LANES-1:0] mem_wr,
  input  logic [LANES-1:0] hit,
  input  logic [LANES-1:0] dirty,
  output logic             stallm,
  output logic [LANES-1:0] we_fill,
  output logic [LANES-1:0] we_word,
  output logic             mem_wb,
  output logic [LW-1:0]    cur_lane,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      miss_count
);

  localparam int CW = $clog2(MEM_LATENCY + 1);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(MEM_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TAG     = 3'd1,
    S_WB      = 3'd2,
    S_FILL    = 3'd3,
    S_FILL_WR = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [LANES-1:0] done_q, done_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [LW-1:0]    cur_q, cur_d;

  logic [LANES-1:0] pending;
  logic [LANES-1:0] cur_oh;
  logic [LANES-1:0] rest;
  logic             hit_cur;
  logic             dirty_cur;
  logic             wr_cur;

  // Scanning downward lets the lowest set bit win.
  function automatic logic [LW-1:0] lowest(input logic [LANES-1:0] v);
    logic [LW-1:0] idx;
    idx = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (v[i]) idx = LW'(i);
    end
    return idx;
  endfunction

  assign pending   = mem_req & ~done_q;
  assign cur_oh    = LANES'(1) << cur_q;
  assign rest      = pending & ~cur_oh;
  assign hit_cur   = |(hit & cur_oh);
  assign dirty_cur = |(dirty & cur_oh);
  assign wr_cur    = |(mem_wr & cur_oh);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      done_q  <= '0;
      cnt_q   <= '0;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    case (state_q)
      S_IDLE: begin
        if (|pending) begin
          cur_d   = lowest(pending);
          state_d = S_TAG;
        end
      end
      S_TAG: begin
        if (hit_cur) begin
          done_d = done_q | cur_oh;
          if (|rest) begin
            cur_d   = lowest(rest);
            state_d = S_TAG;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d   = CNT_RELOAD;
          state_d = dirty_cur ? S_WB : S_FILL;
        end
      end
      S_WB: begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_RELOAD;
          state_d = S_FILL;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FILL: begin
        if (cnt_q == '0) state_d = S_FILL_WR;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_FILL_WR: state_d = S_TAG;
      default:   state_d = S_IDLE;
    endcase
    // Pipeline advanced this edge: the next M bundle starts with nothing serviced.
    if (!stallm) done_d = '0;
  end

  always_comb begin
    stallm   = 1'b0;
    we_fill  = '0;
    we_word  = '0;
    mem_wb   = 1'b0;
    cur_lane = '0;
    if (!rst) begin
      stallm   = (state_q != S_IDLE) || (|pending);
      mem_wb   = (state_q == S_WB);
      cur_lane = cur_q;
      if (state_q == S_FILL_WR)                  we_fill = cur_oh;
      if (state_q == S_TAG && hit_cur && wr_cur) we_word = cur_oh;
    end
  end

`ifdef MEM_STALL_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] miss_q;
  logic        miss_evt;

  assign miss_evt = (state_q == S_TAG) && !hit_cur;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      miss_q  <= '0;
    end else begin
      stall_q <= stall_q + 32'(stallm);
      miss_q  <= miss_q + 32'(miss_evt);
    end
  end

  assign stall_cycles = rst ? 32'd0 : stall_q;
  assign miss_count   = rst ? 32'd0 : miss_q;
`else
  assign stall_cycles = 32'd0;
  assign miss_count   = 32'd0;
`endif

endmodule

// File: tb/tb_mem_stall_sequencer.sv
// Self-checking bench for mem_stall_sequencer (LANES=2, MEM_LATENCY=20): directed cases plus random bundles vs a cost model.
module tb_mem_stall_sequencer;
  localparam int L  = 2;
  localparam int ML = 20;

  logic         clk = 1'b0;
  logic         rst;
  logic [L-1:0] mem_req, mem_wr, hit, dirty;
  logic         stallm, mem_wb;
  logic [L-1:0] we_fill, we_word;
  logic [0:0]   cur_lane;
  logic [31:0]  stall_cycles, miss_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Observations of one bundle
  int obs_stall, obs_wb, obs_viol, obs_fill_cyc;
  int obs_ev[$];
  int obs_cur[$];
  logic [31:0] obs_dstall, obs_dmiss;
  logic [L-1:0] present;

  // Model expectations
  int exp_stall, exp_wb, exp_miss;
  int exp_ev[$];

  mem_stall_sequencer #(.LANES(L), .MEM_LATENCY(ML)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_wr(mem_wr), .hit(hit), .dirty(dirty),
    .stallm(stallm), .we_fill(we_fill), .we_word(we_word), .mem_wb(mem_wb),
    .cur_lane(cur_lane), .stall_cycles(stall_cycles), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  // Cost per serviced lane: hit = 1 TAG; miss = TAG + (WB) + FILL + FILL_WR + re-check TAG.
  task automatic model(input logic [L-1:0] req, wr, h, d);
    exp_ev.delete();
    exp_wb = 0;
    exp_miss = 0;
    exp_stall = (req != 0) ? 1 : 0;
    for (int i = 0; i < L; i++) begin
      if (req[i]) begin
        if (h[i]) exp_stall += 1;
        else begin
          exp_miss += 1;
          exp_stall += d[i] ? (2 * ML + 3) : (ML + 3);
          exp_wb += d[i] ? ML : 0;
          exp_ev.push_back(16 + i);
        end
        if (wr[i]) exp_ev.push_back(32 + i);
      end
    end
  endtask

  function automatic int ev_diff();
    int n;
    n = (obs_ev.size() == exp_ev.size()) ? 0 : 1;
    for (int i = 0; i < obs_ev.size() && i < exp_ev.size(); i++)
      if (obs_ev[i] != exp_ev[i]) n++;
    return n;
  endfunction

  function automatic int lane_of(input logic [L-1:0] v);
    for (int i = 0; i < L; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Drives one M bundle (called #1 after a posedge) and records until the stall releases.
  task automatic run_bundle(input logic [L-1:0] req, wr, h, d);
    logic s;
    logic [31:0] s0, m0;
    s0 = stall_cycles;
    m0 = miss_count;
    obs_stall = 0; obs_wb = 0; obs_viol = 0; obs_fill_cyc = -1;
    obs_ev.delete(); obs_cur.delete();
    mem_req = req; mem_wr = wr; dirty = d;
    present = h; hit = present;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      s = stallm;
      if (stallm) begin
        obs_stall++;
        obs_cur.push_back(int'(cur_lane));
      end
      if (mem_wb) obs_wb++;
      if (we_fill != 0 && we_word != 0) obs_viol++;
      if ($countones(we_fill) > 1 || $countones(we_word) > 1) obs_viol++;
      if (we_fill != 0) begin
        obs_ev.push_back(16 + lane_of(we_fill));
        if (int'(cur_lane) != lane_of(we_fill)) obs_viol++;
        if (obs_fill_cyc < 0) obs_fill_cyc = cyc;
        present = present | we_fill;
        hit = present;
      end
      if (we_word != 0) begin
        obs_ev.push_back(32 + lane_of(we_word));
        if (int'(cur_lane) != lane_of(we_word)) obs_viol++;
      end
      @(posedge clk);
      #1;
      if (!s) break;
    end
    obs_dstall = stall_cycles - s0;
    obs_dmiss = miss_count - m0;
    mem_req = '0; mem_wr = '0; dirty = '0; hit = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_req = 2'b11; mem_wr = 2'b11; hit = '0; dirty = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({stallm, mem_wb, we_fill, we_word, cur_lane} !== 7'd0) $display("FAIL reset_outputs got=%b need=0", {stallm, mem_wb, we_fill, we_word, cur_lane});
    else pass_cnt++;
    total_cnt++;
    if ({stall_cycles, miss_count} !== 64'd0) $display("FAIL reset_perf got=%0d/%0d need=0/0", stall_cycles, miss_count);
    else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0; mem_req = '0; mem_wr = '0; dirty = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_lane0_hit();
    for (int k = 0; k < 2; k++) begin
      run_bundle(2'b01, 2'b00, 2'b01, 2'b00);
      total_cnt++;
      if (obs_stall != 2) $display("FAIL hit0_stall pass%0d got=%0d need=2", k, obs_stall);
      else pass_cnt++;
    end
    total_cnt++;
    if (obs_ev.size() != 0) $display("FAIL hit0_no_we got=%0d pulses need=0", obs_ev.size());
    else pass_cnt++;
  endtask

  task automatic test_lane1_store_hit();
    run_bundle(2'b10, 2'b10, 2'b10, 2'b00);
    model(2'b10, 2'b10, 2'b10, 2'b00);
    total_cnt++;
    if (obs_stall != 2) $display("FAIL st1_stall got=%0d need=2", obs_stall);
    else pass_cnt++;
    total_cnt++;
    if (obs_ev.size() != 1 || obs_ev[0] != 33) $display("FAIL st1_we_word got_n=%0d need 1 word pulse lane1", obs_ev.size());
    else pass_cnt++;
  endtask

  task automatic test_clean_miss();
    run_bundle(2'b01, 2'b00, 2'b00, 2'b00);
    total_cnt++;
    if (obs_stall != 24) $display("FAIL clean_stall got=%0d need=24", obs_stall);
    else pass_cnt++;
    total_cnt++;
    if (obs_fill_cyc != 22) $display("FAIL clean_fill_cycle got=%0d need=22", obs_fill_cyc);
    else pass_cnt++;
    total_cnt++;
    if (obs_wb != 0 || obs_ev.size() != 1 || obs_ev[0] != 16) $display("FAIL clean_events wb=%0d n=%0d need wb=0 n=1", obs_wb, obs_ev.size());
    else pass_cnt++;
  endtask

  task automatic test_dirty_miss();
    run_bundle(2'b01, 2'b01, 2'b00, 2'b01);
    model(2'b01, 2'b01, 2'b00, 2'b01);
    total_cnt++;
    if (obs_stall != 44) $display("FAIL dirty_stall got=%0d need=44", obs_stall);
    else pass_cnt++;
    total_cnt++;
    if (obs_wb != 20) $display("FAIL dirty_mem_wb got=%0d need=20", obs_wb);
    else pass_cnt++;
    total_cnt++;
    if (ev_diff() != 0) $display("FAIL dirty_events got_n=%0d need fill0 then word0", obs_ev.size());
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    run_bundle(2'b11, 2'b00, 2'b11, 2'b00);
    total_cnt++;
    if (obs_stall != 3) $display("FAIL b2b_stall got=%0d need=3", obs_stall);
    else pass_cnt++;
    total_cnt++;
    if (obs_cur.size() < 3 || obs_cur[1] != 0 || obs_cur[2] != 1) $display("FAIL b2b_cur_lane got_n=%0d need lane 0 then 1", obs_cur.size());
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [L-1:0] r, w, h, d;
    for (int k = 0; k < 30; k++) begin
      r = L'($urandom); w = L'($urandom) & r; h = L'($urandom); d = L'($urandom);
      model(r, w, h, d);
      run_bundle(r, w, h, d);
      total_cnt++;
      if (obs_stall != exp_stall || obs_wb != exp_wb) $display("FAIL rnd%0d_timing stall=%0d wb=%0d need %0d/%0d", k, obs_stall, obs_wb, exp_stall, exp_wb);
      else pass_cnt++;
      total_cnt++;
      if (ev_diff() != 0 || obs_viol != 0) $display("FAIL rnd%0d_pulses diff=%0d viol=%0d need 0/0", k, ev_diff(), obs_viol);
      else pass_cnt++;
`ifdef MEM_STALL_PERF_EN
      total_cnt++;
      if (obs_dstall != 32'(exp_stall) || obs_dmiss != 32'(exp_miss)) $display("FAIL rnd%0d_perf got=%0d/%0d need %0d/%0d", k, obs_dstall, obs_dmiss, exp_stall, exp_miss);
      else pass_cnt++;
`else
      total_cnt++;
      if (stall_cycles !== 32'd0 || miss_count !== 32'd0) $display("FAIL rnd%0d_perf_off got=%0d/%0d need 0/0", k, stall_cycles, miss_count);
      else pass_cnt++;
`endif
    end
  endtask

  task automatic test_reset_mid_fill();
    int bad;
    bad = 0;
    mem_req = 2'b01; mem_wr = '0; hit = '0; dirty = '0;
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (stallm !== 1'b0 || we_fill !== 2'b00 || stall_cycles !== 32'd0 || miss_count !== 32'd0)
      $display("FAIL rstfill_in_reset stallm=%b we_fill=%b perf=%0d/%0d need 0", stallm, we_fill, stall_cycles, miss_count);
    else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0; mem_req = '0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (stallm || mem_wb || we_fill != 0 || we_word != 0) bad++;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL rstfill_after activity_cycles=%0d need=0", bad);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; mem_req = '0; mem_wr = '0; hit = '0; dirty = '0; present = '0;
    test_reset();
    test_lane0_hit();
    test_lane1_store_hit();
    test_clean_miss();
    test_dirty_miss();
    test_back_to_back();
    test_random();
    test_reset_mid_fill();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
